// File: rtl/rp_cnn_scheduler.sv
// rp_cnn_scheduler: pops region proposals per frame, launches one CNN
// classification each, reports tagged results and drains the excess.
module rp_cnn_scheduler #(
  parameter int MAX_NUM_OBJ    = 8,
  parameter int X_WIDTH        = 9,
  parameter int Y_WIDTH        = 9,
  parameter int CLASS_WIDTH    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   rp_frame_done,
  input  logic [X_WIDTH-1:0]     region_x,
  input  logic [Y_WIDTH-1:0]     region_y,
  input  logic                   region_valid,
  output logic                   region_rd_en,
  output logic                   cnn_start,
  output logic [X_WIDTH-1:0]     cnn_roi_x,
  output logic [Y_WIDTH-1:0]     cnn_roi_y,
  input  logic                   cnn_done,
  input  logic [CLASS_WIDTH-1:0] cnn_class,
  output logic                   res_valid,
  output logic [X_WIDTH-1:0]     res_x,
  output logic [Y_WIDTH-1:0]     res_y,
  output logic [CLASS_WIDTH-1:0] res_class,
  output logic [3:0]             res_idx,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic [3:0]             obj_count,
  output logic [7:0]             drop_count,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_REPORT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0]  MAX_OBJ  = 4'(MAX_NUM_OBJ);
  localparam logic [16:0] WD_LIMIT = 17'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic        rp_seen;
  logic        rp_seen_n;
  logic [15:0] wdog;
  logic        can_fetch;
  logic        timeout_hit;

  assign can_fetch = obj_count < MAX_OBJ;

  // Fires on the WAIT cycle in which the counter would reach the limit,
  // so REPORT lands exactly TIMEOUT_CYCLES after cnn_start.
  assign timeout_hit = ({1'b0, wdog} + 17'd1) >= WD_LIMIT;

  assign region_rd_en = region_valid &
    (((state == S_FETCH) & can_fetch) | (state == S_DRAIN));

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (frame_start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (region_valid) begin
          state_n = can_fetch ? S_LAUNCH : S_DRAIN;
        end else if (rp_seen || rp_frame_done) begin
          state_n = S_DONE;
        end
      end
      S_LAUNCH: state_n = S_WAIT;
      S_WAIT: begin
        if (cnn_done || timeout_hit) state_n = S_REPORT;
      end
      S_REPORT: state_n = S_FETCH;
      S_DRAIN: begin
        if (!region_valid && rp_seen) state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rp_seen_n = rp_seen | rp_frame_done;
    if (state == S_IDLE) begin
      rp_seen_n = frame_start & rp_frame_done;
    end else if (state == S_DONE) begin
      rp_seen_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rp_seen     <= 1'b0;
      wdog        <= '0;
      cnn_start   <= 1'b0;
      cnn_roi_x   <= '0;
      cnn_roi_y   <= '0;
      res_valid   <= 1'b0;
      res_x       <= '0;
      res_y       <= '0;
      res_class   <= '0;
      res_idx     <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      obj_count   <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_n;
      rp_seen    <= rp_seen_n;
      cnn_start  <= state_n == S_LAUNCH;
      res_valid  <= state_n == S_REPORT;
      frame_done <= state_n == S_DONE;
      frame_busy <= state_n != S_IDLE;
      unique case (state)
        S_IDLE: begin
          if (frame_start) begin
            obj_count   <= '0;
            drop_count  <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_FETCH: begin
          if (region_rd_en) begin
            cnn_roi_x <= region_x;
            cnn_roi_y <= region_y;
          end
        end
        S_LAUNCH: wdog <= '0;
        S_WAIT: begin
          wdog <= wdog + 16'd1;
          if (cnn_done || timeout_hit) begin
            res_x   <= cnn_roi_x;
            res_y   <= cnn_roi_y;
            res_idx <= obj_count;
          end
          if (cnn_done) begin
            res_class <= cnn_class;
          end else if (timeout_hit) begin
            res_class   <= '1;
            timeout_err <= 1'b1;
          end
        end
        S_REPORT: obj_count <= obj_count + 4'd1;
        S_DRAIN: begin
          if (region_valid && drop_count != 8'hff) begin
            drop_count <= drop_count + 8'd1;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rp_cnn_scheduler.sv
// tb_rp_cnn_scheduler: FIFO and CNN models around the scheduler, with a
// frame-level scoreboard of expected results, counts and timing.
module tb_rp_cnn_scheduler;

  localparam int XW   = 9;
  localparam int YW   = 9;
  localparam int CW   = 2;
  localparam int MAXN = 8;
  localparam int TO   = 16;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } roi_t;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic [3:0]    idx;
    int            dt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          rp_frame_done;
  logic [XW-1:0] region_x;
  logic [YW-1:0] region_y;
  logic          region_valid;
  logic          region_rd_en;
  logic          cnn_start;
  logic [XW-1:0] cnn_roi_x;
  logic [YW-1:0] cnn_roi_y;
  logic          cnn_done;
  logic [CW-1:0] cnn_class;
  logic          res_valid;
  logic [XW-1:0] res_x;
  logic [YW-1:0] res_y;
  logic [CW-1:0] res_class;
  logic [3:0]    res_idx;
  logic          frame_busy;
  logic          frame_done;
  logic [3:0]    obj_count;
  logic [7:0]    drop_count;
  logic          timeout_err;

  rp_cnn_scheduler #(
    .MAX_NUM_OBJ(MAXN),
    .X_WIDTH(XW),
    .Y_WIDTH(YW),
    .CLASS_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .rp_frame_done(rp_frame_done),
    .region_x(region_x),
    .region_y(region_y),
    .region_valid(region_valid),
    .region_rd_en(region_rd_en),
    .cnn_start(cnn_start),
    .cnn_roi_x(cnn_roi_x),
    .cnn_roi_y(cnn_roi_y),
    .cnn_done(cnn_done),
    .cnn_class(cnn_class),
    .res_valid(res_valid),
    .res_x(res_x),
    .res_y(res_y),
    .res_class(res_class),
    .res_idx(res_idx),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .obj_count(obj_count),
    .drop_count(drop_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int start_cnt = 0;
  int last_start = 0;
  int first_start = -1;
  int first_pop = -1;
  bit pop_pend = 1'b0;

  roi_t          fifo_q[$];
  exp_t          exp_q[$];
  int            lat_q[$];
  logic [CW-1:0] cls_q[$];
  roi_t          fr_roi[$];
  int            fr_lat[$];
  logic [CW-1:0] fr_cls[$];
  exp_t          mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT region FIFO
  initial begin
    region_valid = 1'b0;
    region_x = '0;
    region_y = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pend = 1'b0;
      #1;
      region_valid = fifo_q.size() > 0;
      if (fifo_q.size() > 0) begin
        region_x = fifo_q[0].x;
        region_y = fifo_q[0].y;
      end
    end
  end

  // CNN core: latency 0 means it never answers
  initial begin
    int l;
    logic [CW-1:0] c;
    cnn_done = 1'b0;
    cnn_class = '0;
    forever begin
      @(negedge clk);
      if (cnn_start && !reset) begin
        l = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        c = (cls_q.size() > 0) ? cls_q.pop_front() : '0;
        if (l > 0) begin
          repeat (l) @(posedge clk);
          #1;
          cnn_done = 1'b1;
          cnn_class = c;
          @(posedge clk);
          #1;
          cnn_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    pop_pend = region_rd_en;
    if (region_rd_en) begin
      n_chk++;
      if (!region_valid) $display("FAIL pop_empty: rd_en=1 valid=%0b need valid=1", region_valid);
      else n_pass++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (cnn_start) begin
      start_cnt++;
      last_start = cyc;
      if (first_start < 0) first_start = cyc;
    end
    if (frame_done) fd_cnt++;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL res_extra: got x=%0d y=%0d idx=%0d, need no result", res_x, res_y, res_idx);
      end else begin
        mon_e = exp_q.pop_front();
        n_chk++;
        if ({res_x, res_y, res_class, res_idx} !== {mon_e.x, mon_e.y, mon_e.c, mon_e.idx})
          $display("FAIL result: got x=%0d y=%0d c=%0d idx=%0d need x=%0d y=%0d c=%0d idx=%0d",
                   res_x, res_y, res_class, res_idx, mon_e.x, mon_e.y, mon_e.c, mon_e.idx);
        else n_pass++;
        n_chk++;
        if (cyc - last_start !== mon_e.dt)
          $display("FAIL res_latency: got %0d need %0d", cyc - last_start, mon_e.dt);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic make_frame(input int n, input int lat);
    roi_t r;
    fr_roi.delete();
    fr_lat.delete();
    fr_cls.delete();
    for (int i = 0; i < n; i++) begin
      r.x = XW'($urandom_range(0, 511));
      r.y = YW'($urandom_range(0, 511));
      fr_roi.push_back(r);
      fr_lat.push_back(lat >= 0 ? lat : ($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 15)));
      fr_cls.push_back(CW'($urandom_range(0, 3)));
    end
  endtask

  // Reference: first MAXN regions classified in order, the rest dropped
  task automatic plan_frame();
    exp_t e;
    for (int i = 0; i < fr_roi.size() && i < MAXN; i++) begin
      e.x = fr_roi[i].x;
      e.y = fr_roi[i].y;
      e.c = (fr_lat[i] == 0) ? {CW{1'b1}} : fr_cls[i];
      e.idx = 4'(i);
      e.dt = (fr_lat[i] == 0) ? TO : fr_lat[i] + 1;
      exp_q.push_back(e);
      lat_q.push_back(fr_lat[i]);
      cls_q.push_back(fr_cls[i]);
    end
  endtask

  task automatic load_fifo();
    foreach (fr_roi[i]) fifo_q.push_back(fr_roi[i]);
    tick();
  endtask

  task automatic go(input bit with_rp, output int fs_cyc);
    fd_cnt = 0;
    start_cnt = 0;
    first_start = -1;
    first_pop = -1;
    frame_start = 1'b1;
    rp_frame_done = with_rp;
    fs_cyc = cyc;
    tick();
    frame_start = 1'b0;
    rp_frame_done = 1'b0;
  endtask

  task automatic wait_frame(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (fd_cnt > 0) ok = 1'b1;
    end
  endtask

  task automatic wait_starts(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (start_cnt >= n) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({region_rd_en, cnn_start, cnn_roi_x, cnn_roi_y, res_valid, res_x, res_y, res_class,
         res_idx, frame_busy, frame_done, obj_count, drop_count, timeout_err} !== '0)
      $display("FAIL reset_outputs: got busy=%0b obj=%0d drop=%0d need all zero",
               frame_busy, obj_count, drop_count);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_three_regions();
    int fs;
    bit ok;
    fr_roi = '{roi_t'{9'd10, 9'd20}, roi_t'{9'd30, 9'd40}, roi_t'{9'd50, 9'd60}};
    fr_lat = '{5, 5, 5};
    fr_cls = '{2'd1, 2'd2, 2'd3};
    plan_frame();
    load_fifo();
    go(1'b1, fs);
    wait_frame(400, ok);
    tick();
    n_chk++;
    if (!ok) $display("FAIL three_done: got no frame_done need frame_done");
    else n_pass++;
    n_chk++;
    if (first_pop !== fs + 1 || first_start !== fs + 2)
      $display("FAIL three_first: got pop=%0d start=%0d need %0d %0d",
               first_pop - fs, first_start - fs, 1, 2);
    else n_pass++;
    n_chk++;
    if ({obj_count, drop_count, timeout_err, frame_busy} !== {4'd3, 8'd0, 1'b0, 1'b0})
      $display("FAIL three_counts: got obj=%0d drop=%0d to=%0b need 3 0 0",
               obj_count, drop_count, timeout_err);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0 || fd_cnt != 1)
      $display("FAIL three_results: got left=%0d fd=%0d need 0 1", exp_q.size(), fd_cnt);
    else n_pass++;
  endtask

  task automatic test_empty_frame();
    int fs;
    go(1'b1, fs);
    n_chk++;
    if (frame_busy !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL empty_c1: got busy=%0b done=%0b need 1 0", frame_busy, frame_done);
    else n_pass++;
    tick();
    n_chk++;
    if (frame_done !== 1'b1)
      $display("FAIL empty_c2: got done=%0b need 1", frame_done);
    else n_pass++;
    tick();
    n_chk++;
    if ({frame_done, frame_busy, obj_count} !== 6'd0 || start_cnt != 0)
      $display("FAIL empty_end: got done=%0b busy=%0b obj=%0d starts=%0d need 0 0 0 0",
               frame_done, frame_busy, obj_count, start_cnt);
    else n_pass++;
  endtask

  task automatic test_drain();
    int fs;
    bit ok;
    make_frame(11, -1);
    fr_lat[2] = 15;
    plan_frame();
    load_fifo();
    go(1'b1, fs);
    wait_frame(1500, ok);
    tick();
    n_chk++;
    if (!ok) $display("FAIL drain_done: got no frame_done need frame_done");
    else n_pass++;
    n_chk++;
    if ({obj_count, drop_count} !== {4'd8, 8'd3} || fifo_q.size() != 0 || start_cnt != 8)
      $display("FAIL drain_counts: got obj=%0d drop=%0d fifo=%0d starts=%0d need 8 3 0 8",
               obj_count, drop_count, fifo_q.size(), start_cnt);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL drain_results: got left=%0d need 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int fs;
    bit ok;
    make_frame(3, 4);
    fr_lat[1] = 0;
    plan_frame();
    load_fifo();
    go(1'b1, fs);
    wait_frame(400, ok);
    tick();
    n_chk++;
    if (!ok || timeout_err !== 1'b1 || obj_count !== 4'd3)
      $display("FAIL timeout_err: got ok=%0b err=%0b obj=%0d need 1 1 3", ok, timeout_err, obj_count);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL timeout_results: got left=%0d need 0", exp_q.size());
    else n_pass++;
    go(1'b0, fs);
    n_chk++;
    if (timeout_err !== 1'b0 || frame_busy !== 1'b1)
      $display("FAIL timeout_clear: got err=%0b busy=%0b need 0 1", timeout_err, frame_busy);
    else n_pass++;
    repeat (3) tick();
    rp_frame_done = 1'b1;
    tick();
    rp_frame_done = 1'b0;
    wait_frame(20, ok);
    n_chk++;
    if (!ok || obj_count !== 4'd0)
      $display("FAIL timeout_next: got ok=%0b obj=%0d need 1 0", ok, obj_count);
    else n_pass++;
  endtask

  task automatic test_trickle();
    int fs;
    bit ok;
    make_frame(4, 5);
    plan_frame();
    go(1'b0, fs);
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(fr_roi[i]);
      if (i < 3) begin
        repeat (10) tick();
        if (i == 1) frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (9) tick();
      end
    end
    wait_starts(4, 40, ok);
    tick();
    rp_frame_done = 1'b1;
    tick();
    rp_frame_done = 1'b0;
    n_chk++;
    if (!ok || frame_done !== 1'b0 || fd_cnt != 0)
      $display("FAIL trickle_wait: got ok=%0b fd=%0d need 1 0", ok, fd_cnt);
    else n_pass++;
    wait_frame(100, ok);
    repeat (4) tick();
    n_chk++;
    if (!ok || fd_cnt != 1 || obj_count !== 4'd4 || drop_count !== 8'd0)
      $display("FAIL trickle_end: got ok=%0b fd=%0d obj=%0d drop=%0d need 1 1 4 0",
               ok, fd_cnt, obj_count, drop_count);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0 || frame_busy !== 1'b0)
      $display("FAIL trickle_results: got left=%0d busy=%0b need 0 0", exp_q.size(), frame_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int fs;
    bit ok;
    fr_roi = '{roi_t'{9'd7, 9'd9}, roi_t'{9'd11, 9'd13}, roi_t'{9'd15, 9'd17}};
    fr_lat = '{0, 5, 5};
    fr_cls = '{2'd1, 2'd2, 2'd0};
    plan_frame();
    load_fifo();
    go(1'b1, fs);
    wait_starts(1, 20, ok);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_chk++;
    if (!ok || {region_rd_en, cnn_start, cnn_roi_x, cnn_roi_y, res_valid, res_x, res_y,
                res_class, res_idx, frame_busy, frame_done, obj_count, drop_count,
                timeout_err} !== '0)
      $display("FAIL reset_mid_outputs: got roi=%0d,%0d busy=%0b need all zero",
               cnn_roi_x, cnn_roi_y, frame_busy);
    else n_pass++;
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    cls_q.delete();
    repeat (5) tick();
    n_chk++;
    if (fd_cnt != 0 || fifo_q.size() != 2 || frame_busy !== 1'b0)
      $display("FAIL reset_mid_abort: got fd=%0d fifo=%0d busy=%0b need 0 2 0",
               fd_cnt, fifo_q.size(), frame_busy);
    else n_pass++;
    fifo_q.delete();
    tick();
    make_frame(2, 3);
    plan_frame();
    load_fifo();
    go(1'b1, fs);
    wait_frame(200, ok);
    tick();
    n_chk++;
    if (!ok || obj_count !== 4'd2 || exp_q.size() != 0)
      $display("FAIL reset_mid_next: got ok=%0b obj=%0d left=%0d need 1 2 0",
               ok, obj_count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int fs;
    int n;
    int ne;
    bit ok;
    bit te;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 12);
      make_frame(n, -1);
      ne = (n < MAXN) ? n : MAXN;
      te = 1'b0;
      for (int i = 0; i < ne; i++) if (fr_lat[i] == 0) te = 1'b1;
      plan_frame();
      load_fifo();
      go(1'b1, fs);
      wait_frame(1500, ok);
      tick();
      n_chk++;
      if (!ok || obj_count !== 4'(ne) || drop_count !== 8'(n - ne) || timeout_err !== te)
        $display("FAIL random_frame%0d: got ok=%0b obj=%0d drop=%0d to=%0b need 1 %0d %0d %0b",
                 f, ok, obj_count, drop_count, timeout_err, ne, n - ne, te);
      else n_pass++;
      n_chk++;
      if (exp_q.size() != 0 || fifo_q.size() != 0 || start_cnt != ne)
        $display("FAIL random_left%0d: got exp=%0d fifo=%0d starts=%0d need 0 0 %0d",
                 f, exp_q.size(), fifo_q.size(), start_cnt, ne);
      else n_pass++;
      repeat (2) tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    rp_frame_done = 1'b0;
    test_reset();
    test_three_regions();
    test_empty_frame();
    test_drain();
    test_timeout();
    test_trickle();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
